// File: rtl/uart_bus_bridge.sv
// rtl/uart_bus_bridge.sv - UART command frames to single-word system bus writes/reads
module uart_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        system_bus_en,
    output logic        system_bus_rdwr,
    output logic [3:0]  system_bus_mask,
    output logic [31:0] system_bus_addr,
    output logic [31:0] system_bus_wr_data,
    input  logic [31:0] system_bus_rd_data,
    output logic        busy,
    output logic        rx_overrun
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_ACCESS,
        S_RWAIT,
        S_ACK,
        S_NAK,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_is_wr;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [1:0]    r_cnt;
    logic [TW-1:0] r_tcnt;
    logic          r_overrun;

    logic          w_is_cmd;
    logic          w_timeout;
    logic          w_rx_blocked;
    logic [7:0]    w_rbyte;

    assign w_is_cmd  = (rx_data == CMD_WR) || (rx_data == CMD_RD);
    assign w_timeout = !rx_valid && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_rbyte   = 8'(r_rdata >> {r_cnt, 3'b000});
    // Bytes can only be taken while collecting a frame (IDLE/ADDR/DATA).
    assign w_rx_blocked = (r_state != S_IDLE) && (r_state != S_ADDR) && (r_state != S_DATA);

    assign system_bus_addr    = {r_addr[31:2], 2'b00};
    assign system_bus_wr_data = r_wdata;
    assign busy               = (r_state != S_IDLE);
    assign rx_overrun         = r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        tx_valid        = 1'b0;
        tx_data         = 8'h00;
        bus_req         = 1'b0;
        system_bus_en   = 1'b0;
        system_bus_rdwr = 1'b0;
        system_bus_mask = 4'h0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_next = w_is_cmd ? S_ADDR : S_NAK;
                end
            end
            S_ADDR: begin
                if (rx_valid && (r_cnt == 2'd3)) begin
                    w_next = r_is_wr ? S_DATA : S_REQ;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid && (r_cnt == 2'd3)) begin
                    w_next = S_REQ;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                bus_req         = 1'b1;
                system_bus_en   = 1'b1;
                system_bus_rdwr = r_is_wr;
                system_bus_mask = 4'hF;
                w_next          = r_is_wr ? S_ACK : S_RWAIT;
            end
            S_RWAIT: begin
                bus_req = 1'b1;
                w_next  = S_RESP;
            end
            S_ACK: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
                if (tx_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_NAK: begin
                tx_valid = 1'b1;
                tx_data  = NAK_BYTE;
                if (tx_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_RESP: begin
                tx_valid = 1'b1;
                tx_data  = w_rbyte;
                if (tx_ready && (r_cnt == 2'd3)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_cnt wraps to 0 after each 4-byte field, so it is already cleared for the next phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_wr   <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_cnt     <= 2'd0;
            r_tcnt    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (rx_valid && w_rx_blocked) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (rx_valid && w_is_cmd) begin
                        r_is_wr <= (rx_data == CMD_WR);
                        r_cnt   <= 2'd0;
                        r_tcnt  <= '0;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        r_addr <= {rx_data, r_addr[31:8]};
                        r_cnt  <= r_cnt + 2'd1;
                        r_tcnt <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_wdata <= {rx_data, r_wdata[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                        r_tcnt  <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_RWAIT: begin
                    r_rdata <= system_bus_rd_data;
                end
                S_RESP: begin
                    if (tx_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb/tb_uart_bus_bridge.sv - self-checking bench for uart_bus_bridge
module tb_uart_bus_bridge;

    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic        system_bus_en;
    logic        system_bus_rdwr;
    logic [3:0]  system_bus_mask;
    logic [31:0] system_bus_addr;
    logic [31:0] system_bus_wr_data;
    logic [31:0] system_bus_rd_data;
    logic        busy;
    logic        rx_overrun;

    logic        gnt_force = 1'b1;
    logic        gnt_rand = 1'b0;
    logic        gnt_rnd = 1'b1;
    logic        ready_force = 1'b1;
    logic        ready_rand = 1'b0;
    logic        ready_rnd = 1'b1;
    logic [31:0] rd_val = 32'h0;

    assign bus_gnt            = gnt_rand ? gnt_rnd : gnt_force;
    assign tx_ready           = ready_rand ? ready_rnd : ready_force;
    assign system_bus_rd_data = rd_val;

    uart_bus_bridge #(.TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .system_bus_en(system_bus_en), .system_bus_rdwr(system_bus_rdwr),
        .system_bus_mask(system_bus_mask), .system_bus_addr(system_bus_addr),
        .system_bus_wr_data(system_bus_wr_data), .system_bus_rd_data(system_bus_rd_data),
        .busy(busy), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        gnt_rnd   = ($urandom_range(0, 2) == 0);
        ready_rnd = ($urandom_range(0, 2) != 0);
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_acc[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    int          checks = 0;
    int          failures = 0;
    int          en_cycles = 0;
    logic        last_wr = 1'b0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_data = 32'h0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {46'b0, tx_valid, tx_data, bus_req, system_bus_en, system_bus_rdwr,
                             system_bus_mask, busy, rx_overrun}, 64'h0);
        chk({tag, "_bus"}, {system_bus_addr, system_bus_wr_data}, 64'h0);
    endtask

    // Compare process: every bus strobe and tx handshake is matched against the model queues.
    always @(negedge clk) begin : compare
        acc_t a;
        if (rst) begin
            exp_acc.delete();
            exp_tx.delete();
            stall_prev = 1'b0;
        end else begin
            if (system_bus_en) begin
                en_cycles++;
                last_wr   = system_bus_rdwr;
                last_addr = system_bus_addr;
                last_data = system_bus_wr_data;
                if (exp_acc.size() == 0) begin
                    chk("unexpected_access", 64'(system_bus_en), 64'h0);
                end else begin
                    a = exp_acc.pop_front();
                    chk("acc_rdwr", 64'(system_bus_rdwr), 64'(a.wr));
                    chk("acc_addr", 64'(system_bus_addr), 64'(a.addr));
                    chk("acc_mask_req", {59'b0, system_bus_mask, bus_req}, 64'h1F);
                    if (a.wr) chk("acc_wdata", 64'(system_bus_wr_data), 64'(a.data));
                end
            end else begin
                chk("idle_bus_zero", {59'b0, system_bus_rdwr, system_bus_mask}, 64'h0);
            end
            if (tx_valid && tx_ready) begin
                tx_log.push_back(tx_data);
                if (exp_tx.size() == 0) chk("unexpected_tx", 64'(tx_valid), 64'h0);
                else chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
            end
            if (stall_prev) chk("tx_hold", {55'b0, tx_valid, tx_data}, {55'b0, 1'b1, stall_data});
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] data, input int gap_max);
        acc_t a;
        a.wr   = (op == 8'h57);
        a.addr = {addr[31:2], 2'b00};
        a.data = data;
        if (op == 8'h57) begin
            exp_acc.push_back(a);
            exp_tx.push_back(8'h4B);
        end else if (op == 8'h52) begin
            exp_acc.push_back(a);
            for (int i = 0; i < 4; i++) exp_tx.push_back(rd_val[8*i +: 8]);
        end else begin
            exp_tx.push_back(8'h3F);
        end
        send_byte(op);
        if (op == 8'h57 || op == 8'h52) begin
            for (int i = 0; i < 4; i++) begin
                cyc($urandom_range(0, gap_max));
                send_byte(addr[8*i +: 8]);
            end
        end
        if (op == 8'h57) begin
            for (int i = 0; i < 4; i++) begin
                cyc($urandom_range(0, gap_max));
                send_byte(data[8*i +: 8]);
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((busy || exp_acc.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
            cyc(1);
            n++;
        end
        chk({name, "_done"}, {63'b0, busy}, 64'h0);
        chk({name, "_pending"}, 64'(exp_acc.size() + exp_tx.size()), 64'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [7:0] op;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        cyc(2);

        en_cycles = 0;
        tx_log.delete();
        send_frame(8'h57, 32'h80000000, 32'hDEADBEEF, 0);
        wait_done("t_write");
        chk("t_write_en_cycles", 64'(en_cycles), 64'd1);
        chk("t_write_rdwr", 64'(last_wr), 64'd1);
        chk("t_write_addr", 64'(last_addr), 64'h80000000);
        chk("t_write_data", 64'(last_data), 64'hDEADBEEF);
        chk("t_write_txn", 64'(tx_log.size()), 64'd1);
        if (tx_log.size() != 0) chk("t_write_ack", 64'(tx_log[0]), 64'h4B);

        en_cycles = 0;
        tx_log.delete();
        rd_val = 32'h12345678;
        send_frame(8'h52, 32'h90000007, 32'h0, 0);
        wait_done("t_read");
        chk("t_read_addr", {31'b0, last_wr, last_addr}, 64'h90000004);
        if (tx_log.size() == 4)
            chk("t_read_bytes", 64'({tx_log[3], tx_log[2], tx_log[1], tx_log[0]}), 64'h12345678);
        else
            chk("t_read_txn", 64'(tx_log.size()), 64'd4);

        en_cycles = 0;
        tx_log.delete();
        send_frame(8'hAA, 32'h0, 32'h0, 0);
        wait_done("t_nak");
        chk("t_nak_no_bus", 64'(en_cycles), 64'd0);
        if (tx_log.size() != 0) chk("t_nak_byte", 64'(tx_log[0]), 64'h3F);
        else chk("t_nak_txn", 64'(tx_log.size()), 64'd1);
        rd_val = 32'hA5C3_0F1E;
        send_frame(8'h52, 32'h0000_0104, 32'h0, 1);
        wait_done("t_after_nak");
        chk("t_after_nak_en", 64'(en_cycles), 64'd1);

        gnt_force = 1'b0;
        en_cycles = 0;
        send_frame(8'h57, 32'h0000_2000, 32'h1122_3344, 0);
        chk("t_gnt_req_latency", 64'(bus_req), 64'd1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!bus_req || system_bus_en) bad++;
        end
        chk("t_gnt_hold", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        gnt_force = 1'b1;
        @(negedge clk);
        chk("t_gnt_no_early_en", 64'(system_bus_en), 64'd0);
        @(negedge clk);
        chk("t_gnt_strobe", 64'(system_bus_en), 64'd1);
        wait_done("t_gnt");

        en_cycles = 0;
        tx_log.delete();
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h02);
        cyc(8);
        chk("t_tout_still_busy", 64'(busy), 64'd1);
        cyc(12);
        chk("t_tout_idle", 64'(busy), 64'd0);
        chk("t_tout_silent", 64'(en_cycles + tx_log.size()), 64'd0);
        send_frame(8'h57, 32'h0000_0040, 32'h5555_AAAA, 2);
        wait_done("t_tout_next");
        chk("t_tout_next_en", 64'(en_cycles), 64'd1);

        gnt_rand = 1'b1;
        ready_rand = 1'b1;
        for (int f = 0; f < 150; f++) begin
            case ($urandom_range(0, 4))
                0, 1: op = 8'h57;
                2, 3: op = 8'h52;
                default: begin
                    op = 8'($urandom_range(0, 255));
                    if (op == 8'h57 || op == 8'h52) op = 8'h00;
                end
            endcase
            rd_val = $urandom;
            send_frame(op, $urandom, $urandom, 4);
            wait_done("t_rand");
        end
        gnt_rand = 1'b0;
        ready_rand = 1'b0;
        gnt_force = 1'b1;
        ready_force = 1'b0;

        rd_val = 32'hCAFE_F00D;
        send_frame(8'h52, 32'h0000_0300, 32'h0, 0);
        bad = 0;
        while (!tx_valid && bad < 20) begin
            cyc(1);
            bad++;
        end
        chk("t_stall_txvalid", 64'(tx_valid), 64'd1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h0D) bad++;
            if (c == 4) send_byte(8'h57);
        end
        chk("t_stall_stable", 64'(bad), 64'd0);
        chk("t_stall_overrun", 64'(rx_overrun), 64'd1);
        chk("t_stall_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("t_midresp_reset");
        cyc(2);
        rst = 1'b0;
        ready_force = 1'b1;
        en_cycles = 0;
        tx_log.delete();
        cyc(5);
        chk("t_post_reset_quiet", 64'(en_cycles + tx_log.size()), 64'd0);
        send_frame(8'h57, 32'h0000_0500, 32'h0BAD_F00D, 1);
        wait_done("t_post_reset");
        chk("t_post_reset_en", 64'(en_cycles), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Debug/boot initiator on the system bus. It consumes framed command bytes from the UART receive path and issues single-word writes or reads on the same bus the CPU drives, so memory, the GEMM configuration space and peripherals can be loaded or inspected from the host.
- It returns an ack byte or read data on the UART transmit path.
- It arbitrates with the CPU through a req/gnt handshake to the bus mux in top.

Parameters:
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between bytes of one frame before the frame is aborted.
- ACK_BYTE, 8'h4B: byte sent after a completed write.
- NAK_BYTE, 8'h3F: byte sent for an unknown command byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- rx_data  in  8  received byte
- tx_valid  out  1  transmit byte available
- tx_data  out  8  transmit byte; held stable while tx_valid=1 and tx_ready=0
- tx_ready  in  1  transmitter accepts byte; transfer occurs when tx_valid and tx_ready are both 1
- bus_req  out  1  request for bus ownership
- bus_gnt  in  1  bus ownership granted (CPU stalled)
- system_bus_en  out  1  access strobe, one cycle
- system_bus_rdwr  out  1  1=write, 0=read
- system_bus_mask  out  4  byte mask, always 4'hF during an access
- system_bus_addr  out  32  word address, bits [1:0] forced to 0
- system_bus_wr_data  out  32  write data
- system_bus_rd_data  in  32  read data, valid the cycle after a read strobe
- busy  out  1  high in every state except IDLE
- rx_overrun  out  1  sticky flag; a byte arrived while the bridge could not accept it

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0, the FSM is in IDLE, and the shift registers and counters are cleared. Reset mid-frame or mid-access abandons the operation; no partial bus strobe or tx byte is emitted afterwards.
- Frame format:
  - Write: 'W' (8'h57), then 4 address bytes, then 4 data bytes.
  - Read: 'R' (8'h52), then 4 address bytes.
  - Multi-byte fields are little-endian (first byte lands in [7:0]).
- FSM states:
  - IDLE:
    - rx 'W' or 'R' -> ADDR; latch the operation; byte count cleared.
    - Any other byte -> NAK; tx_data=NAK_BYTE.
  - ADDR: 4 bytes are shifted in. On the 4th byte, a write goes to DATA and a read goes to REQ.
  - DATA: 4 bytes are shifted in. On the 4th byte -> REQ.
  - REQ: bus_req=1 and held until bus_gnt=1, then -> ACCESS.
  - ACCESS (one cycle):
    - Drives system_bus_en=1, rdwr=op, mask=4'hF, addr={addr[31:2],2'b00}, wr_data.
    - bus_req stays 1.
    - Write -> ACK. Read -> RWAIT.
  - RWAIT (one cycle):
    - Captures system_bus_rd_data into the response register; bus_req stays 1.
    - -> RESP.
    - bus_req drops on exit.
  - ACK / NAK: tx_valid=1 with the fixed byte; on handshake -> IDLE.
  - RESP: 4 bytes are sent, [7:0] first, each on its own tx handshake. The byte counter advances only on handshake. After the 4th -> IDLE.
- Bus outputs: en/rdwr/mask are 0 outside ACCESS. Addr and wr_data may hold their last value.
- Latency: bus_req rises the cycle after the last frame byte. The strobe comes the cycle after bus_gnt is seen high. If bus_gnt is already high, the strobe follows in the next cycle.
- bus_gnt dropping during ACCESS/RWAIT is ignored; the transfer completes.
- Timeout:
  - In ADDR and DATA, a counter resets on each rx_valid and increments otherwise.
  - On reaching TIMEOUT_CYCLES-1 -> IDLE silently (no tx, no bus access).
  - The counter is inactive in all other states.
- Overrun:
  - rx_valid in REQ, ACCESS, RWAIT, ACK, NAK or RESP drops the byte and sets rx_overrun=1 until reset.
  - Such a byte never starts a new frame.
- rx_valid and a tx handshake in the same cycle: the tx handshake completes and the rx byte is an overrun.
- tx_data must not change between assertion of tx_valid and its handshake.

Test Plan:
- Write frame 57 00 00 00 80 EF BE AD DE, bus_gnt tied 1 -> exactly one cycle en=1, rdwr=1, mask=F, addr=32'h80000000, wr_data=32'hDEADBEEF; then tx 8'h4B; busy low afterwards.
- Read frame 52 07 00 00 90, rd_data=32'h12345678 the cycle after the strobe -> addr=32'h90000004, rdwr=0; tx bytes 78, 56, 34, 12 in order.
- Byte 8'hAA in IDLE -> tx 8'h3F, no bus activity; a following valid 'R' frame is serviced normally.
- bus_gnt held 0 for 50 cycles after a complete write frame -> bus_req=1 for all 50 cycles, no en; strobe exactly 1 cycle after gnt rises.
- TIMEOUT_CYCLES=16; send 57 01 02 then silence for 20 cycles -> return to IDLE, no tx, no en; the next full frame works.
- tx_ready held 0 for 10 cycles during RESP, extra rx byte injected, reset asserted mid-RESP:
  - tx_data stable throughout the stall.
  - rx_overrun=1.
  - After reset, all outputs are 0 immediately.
